// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer handshake bundle for sync_fifo
interface sync_fifo_if #(
  parameter int DATA_W = 128
);
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;

  modport master (
    output i_wren, i_wrdata, i_rden,
    input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden,
    output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and level flags
module sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int UPP_TH = 4,
  parameter int LOW_TH = 2
) (
  input logic       clk,
  input logic       rstn,
  sync_fifo_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_rddata;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Flags decode the registered count, so they gate the requests of the coming edge.
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr_ok = fifo.i_wren & ~w_full;
  assign w_rd_ok = fifo.i_rden & ~w_empty;

  assign fifo.o_full      = w_full;
  assign fifo.o_empty     = w_empty;
  assign fifo.o_alm_full  = (r_count >= (AW+1)'(DEPTH - UPP_TH));
  assign fifo.o_alm_empty = (r_count <= (AW+1)'(LOW_TH));
  assign fifo.o_rddata    = r_rddata;

  // Array is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rstn && w_wr_ok) begin
      r_mem[r_wr_ptr] <= fifo.i_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rddata <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rddata <= r_mem[r_rd_ptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (DEPTH=16, DATA_W=8)
module tb_sync_fifo;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  sync_fifo_if #(.DATA_W(8)) fif ();

  sync_fifo #(
    .DATA_W(8),
    .DEPTH (16),
    .UPP_TH(4),
    .LOW_TH(2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .fifo(fif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, "_empty"},     32'(fif.o_empty),     32'(cnt == 0));
    chk({tag, "_full"},      32'(fif.o_full),      32'(cnt == 16));
    chk({tag, "_alm_empty"}, 32'(fif.o_alm_empty), 32'(cnt <= 2));
    chk({tag, "_alm_full"},  32'(fif.o_alm_full),  32'(cnt >= 12));
    chk({tag, "_count"},     32'(dut.r_count),     32'(cnt));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    fif.i_wren   = 1'b0;
    fif.i_rden   = 1'b0;
    fif.i_wrdata = 8'h00;
    rstn         = 1'b1;
    tick();
    tick();
    chk_flags("reset", 0);
    chk("reset_rddata", 32'(fif.o_rddata), 32'h0);
    rstn = 1'b0;

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      fif.i_wren   = 1'b1;
      fif.i_wrdata = 8'(i);
      tick();
      chk_flags($sformatf("fill%0d", i), i);
    end
    fif.i_wrdata = 8'hFF;
    tick();
    chk_flags("overfill", 16);
    fif.i_wren = 1'b0;

    // drain; the dropped 0xFF must never appear
    for (int i = 1; i <= 16; i++) begin
      fif.i_rden = 1'b1;
      tick();
      chk($sformatf("drain%0d_data", i), 32'(fif.o_rddata), 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(dut.r_count), 32'(16 - i));
    end
    chk_flags("drained", 0);
    tick();
    chk("underread_data", 32'(fif.o_rddata), 32'h10);
    chk_flags("underread", 0);
    fif.i_rden = 1'b0;

    // preload 5 words 0x20..0x24, then 20 cycles of wr+rd
    for (int i = 0; i < 5; i++) begin
      fif.i_wren   = 1'b1;
      fif.i_wrdata = 8'(8'h20 + i);
      tick();
    end
    chk_flags("preload", 5);
    for (int k = 0; k < 20; k++) begin
      fif.i_wren   = 1'b1;
      fif.i_rden   = 1'b1;
      fif.i_wrdata = 8'(8'h25 + k);
      tick();
      chk($sformatf("conc%0d_data", k), 32'(fif.o_rddata), 32'(8'h20 + k));
      chk($sformatf("conc%0d_count", k), 32'(dut.r_count), 32'd5);
    end
    fif.i_wren = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fif.i_rden = 1'b1;
      tick();
      chk($sformatf("tail%0d_data", k), 32'(fif.o_rddata), 32'(8'h34 + k));
    end
    chk_flags("tail_done", 0);

    // wr+rd while empty: only the write lands
    fif.i_wren   = 1'b1;
    fif.i_rden   = 1'b1;
    fif.i_wrdata = 8'hAA;
    tick();
    chk("emptywr_data", 32'(fif.o_rddata), 32'h38);
    chk_flags("emptywr", 1);
    fif.i_wren = 1'b0;
    tick();
    chk("emptywr_read", 32'(fif.o_rddata), 32'hAA);
    chk_flags("emptywr_rd", 0);
    fif.i_rden = 1'b0;

    // reset mid-stream with count=9 and a pending write
    for (int i = 0; i < 9; i++) begin
      fif.i_wren   = 1'b1;
      fif.i_wrdata = 8'(8'h40 + i);
      tick();
    end
    chk_flags("pre_rst", 9);
    fif.i_wrdata = 8'h55;
    rstn         = 1'b1;
    tick();
    rstn       = 1'b0;
    fif.i_wren = 1'b0;
    chk_flags("midrst", 0);
    chk("midrst_data", 32'(fif.o_rddata), 32'h0);
    fif.i_rden = 1'b1;
    tick();
    chk_flags("midrst_rd", 0);
    chk("midrst_rd_data", 32'(fif.o_rddata), 32'h0);
    fif.i_rden = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
